// File: rtl/inst_mem.sv
// rtl/inst_mem.sv - byte-addressed instruction memory with boot image and loader write port
// Optional PC fault flag when INST_MEM_ALIGN_CHECK_EN is defined.
module inst_mem #(
    parameter int MEM_BYTES = 64,
    parameter int ADDR_BITS = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] PC,
    output logic [31:0] Instruction_Code,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data
`ifdef INST_MEM_ALIGN_CHECK_EN
    ,
    output logic        instr_fault
`endif
);

    logic [7:0]           mem [MEM_BYTES];
    logic [ADDR_BITS-1:0] rd_idx [4];
    logic [ADDR_BITS-1:0] wr_base;

    function automatic logic [7:0] boot_byte(input int unsigned i);
        logic [31:0] word;
        case (i >> 2)
            0:       word = 32'h009403B3;
            1:       word = 32'h41348433;
            2:       word = 32'h0094F533;
            3:       word = 32'h0094E5B3;
            default: word = 32'h00000013;
        endcase
        return word[8*i[1:0] +: 8];
    endfunction

    assign wr_base = {wr_addr[ADDR_BITS-1:2], 2'b00};

    // Reset wins over a coincident write because it is checked first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MEM_BYTES; i++) begin
                mem[i] <= boot_byte(i);
            end
        end else if (wr_en) begin
            mem[wr_base | ADDR_BITS'(0)] <= wr_data[7:0];
            mem[wr_base | ADDR_BITS'(1)] <= wr_data[15:8];
            mem[wr_base | ADDR_BITS'(2)] <= wr_data[23:16];
            mem[wr_base | ADDR_BITS'(3)] <= wr_data[31:24];
        end
    end

    // Index arithmetic is ADDR_BITS wide, so PC+k wraps modulo MEM_BYTES.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            rd_idx[k] = PC[ADDR_BITS-1:0] + ADDR_BITS'(k);
        end
    end

    assign Instruction_Code = {mem[rd_idx[3]], mem[rd_idx[2]], mem[rd_idx[1]], mem[rd_idx[0]]};

`ifdef INST_MEM_ALIGN_CHECK_EN
    assign instr_fault = (PC[1:0] != 2'b00) || (PC[31:ADDR_BITS] != '0);
`endif

    logic unused_bits;
    assign unused_bits = &{1'b0, PC[31:ADDR_BITS], wr_addr[31:ADDR_BITS], wr_addr[1:0]};

endmodule

// File: tb/tb_inst_mem.sv
// tb/tb_inst_mem.sv - self-checking bench for inst_mem
module tb_inst_mem;

    localparam int MEM_BYTES = 64;
    localparam int ADDR_BITS = 6;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] PC = '0;
    logic [31:0] Instruction_Code;
    logic        wr_en = 1'b0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
`ifdef INST_MEM_ALIGN_CHECK_EN
    logic        instr_fault;
`endif

    int errors = 0;
    int checks = 0;

    logic [7:0] ref_mem [MEM_BYTES];

    inst_mem #(.MEM_BYTES(MEM_BYTES), .ADDR_BITS(ADDR_BITS)) dut (
        .clk(clk),
        .reset(reset),
        .PC(PC),
        .Instruction_Code(Instruction_Code),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data)
`ifdef INST_MEM_ALIGN_CHECK_EN
        ,
        .instr_fault(instr_fault)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] exp_code;
        logic        exp_fault;
    } vec_t;

    vec_t vecs [12];

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, got, exp);
        end
    endtask

    task automatic check_fault(input string name, input logic [31:0] pc, input logic exp);
`ifdef INST_MEM_ALIGN_CHECK_EN
        checks++;
        if (instr_fault !== exp) begin
            errors++;
            $display("FAIL %s: pc %08h fault got %b expected %b", name, pc, instr_fault, exp);
        end
`else
        if (pc === 32'hx && exp === 1'bx) $display("unreachable");
`endif
    endtask

    function automatic void ref_boot();
        logic [31:0] words [4];
        words = '{32'h009403B3, 32'h41348433, 32'h0094F533, 32'h0094E5B3};
        for (int i = 0; i < MEM_BYTES; i++) begin
            logic [31:0] w;
            w = (i < 16) ? words[i / 4] : 32'h00000013;
            ref_mem[i] = 8'((w >> (8 * (i % 4))) & 32'hFF);
        end
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] pc);
        logic [31:0] r;
        r = 0;
        for (int k = 0; k < 4; k++) begin
            r = r | (32'(ref_mem[(pc + k) % MEM_BYTES]) << (8 * k));
        end
        return r;
    endfunction

    function automatic void ref_write(input logic [31:0] addr, input logic [31:0] data);
        int base;
        base = int'(addr % MEM_BYTES) / 4 * 4;
        for (int k = 0; k < 4; k++) begin
            ref_mem[base + k] = 8'((data >> (8 * k)) & 32'hFF);
        end
    endfunction

    function automatic logic ref_fault(input logic [31:0] pc);
        return (pc % 4 != 0) || (pc >= MEM_BYTES);
    endfunction

    task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        wr_en = 1'b1;
        wr_addr = addr;
        wr_data = data;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        ref_write(addr, data);
    endtask

    initial begin
        vecs[0]  = '{32'h0000_0000, 32'h009403B3, 1'b0};
        vecs[1]  = '{32'h0000_0004, 32'h41348433, 1'b0};
        vecs[2]  = '{32'h0000_0008, 32'h0094F533, 1'b0};
        vecs[3]  = '{32'h0000_000C, 32'h0094E5B3, 1'b0};
        vecs[4]  = '{32'h0000_0010, 32'h00000013, 1'b0};
        vecs[5]  = '{32'h0000_0040, 32'h009403B3, 1'b1};
        vecs[6]  = '{32'h0000_0002, 32'h84330094, 1'b1};
        vecs[7]  = '{32'h0000_0001, 32'h33009403, 1'b1};
        vecs[8]  = '{32'h0000_003E, 32'h03B30000, 1'b1};
        vecs[9]  = '{32'h0000_0100, 32'h009403B3, 1'b1};
        vecs[10] = '{32'hFFFF_FFFC, 32'h00000013, 1'b1};
        vecs[11] = '{32'h0000_003C, 32'h00000013, 1'b0};

        // Reads are valid while reset is held.
        reset = 1'b1;
        #12;
        for (int i = 0; i < 4; i++) begin
            PC = vecs[i].pc;
            #1;
            check32("reset_held_read", Instruction_Code, vecs[i].exp_code);
        end
        @(negedge clk);
        reset = 1'b0;
        ref_boot();

        for (int i = 0; i < 12; i++) begin
            PC = vecs[i].pc;
            #1;
            check32("table_read", Instruction_Code, vecs[i].exp_code);
            check_fault("table_fault", vecs[i].pc, vecs[i].exp_fault);
        end

        // Same-cycle read: old data before the edge, new data after.
        @(negedge clk);
        PC = 32'd4;
        wr_en = 1'b1;
        wr_addr = 32'd4;
        wr_data = 32'hDEADBEEF;
        #1;
        check32("pre_edge_old", Instruction_Code, 32'h41348433);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        ref_write(32'd4, 32'hDEADBEEF);
        check32("post_edge_new", Instruction_Code, 32'hDEADBEEF);

        // Low address bits of wr_addr are ignored.
        write_word(32'd11, 32'h12345678);
        PC = 32'd8;
        #1;
        check32("wr_addr_low_ignored", Instruction_Code, 32'h12345678);
        PC = 32'd6;
        #1;
        check32("unaligned_across_written", Instruction_Code, 32'h5678DEAD);

        // Async reset mid-cycle restores the image immediately.
        write_word(32'd0, 32'hDEADBEEF);
        PC = 32'd0;
        #1;
        check32("written_before_reset", Instruction_Code, 32'hDEADBEEF);
        #2;
        reset = 1'b1;
        #1;
        check32("async_reset_restores", Instruction_Code, 32'h009403B3);
        PC = 32'd4;
        #1;
        check32("reset_drops_loader_writes", Instruction_Code, 32'h41348433);
        #1;
        reset = 1'b0;
        ref_boot();

        // Write coincident with reset is discarded.
        @(negedge clk);
        reset = 1'b1;
        wr_en = 1'b1;
        wr_addr = 32'd8;
        wr_data = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        PC = 32'd8;
        #1;
        check32("reset_beats_write", Instruction_Code, 32'h0094F533);

        // Randomized writes and reads against the byte-array model.
        for (int n = 0; n < 200; n++) begin
            logic [31:0] pc;
            if ($urandom_range(0, 1) == 1) begin
                write_word($urandom, $urandom);
            end
            pc = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, MEM_BYTES - 1));
            @(negedge clk);
            PC = pc;
            #1;
            check32("random_read", Instruction_Code, ref_read(pc));
            check_fault("random_fault", pc, ref_fault(pc));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
